// File: rtl/calc_sequencer.sv
// calc_sequencer: debounced two-operand calculator front end driving a shared arithmetic unit
module calc_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  btn,
  output logic [6:0]  op_a,
  output logic [6:0]  op_b,
  output logic [2:0]  op_sel,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [13:0] alu_result,
  input  logic        alu_neg,
  output logic [13:0] disp_value,
  output logic        disp_mode,
  output logic        disp_neg,
  output logic        err,
  output logic        busy
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  typedef enum logic [1:0] {S_ENTRY, S_ISSUE, S_WAIT, S_SHOW} state_t;
  state_t state, state_n;
  logic [8:0] sync1, sync2, lvl, lvl_d, press;
  logic [DW-1:0] cnt [9];
  logic [3:0] dig [4];
  logic [3:0] dig_n [4];
  logic [2:0] op_n;
  logic [13:0] res, res_n, entry_val;
  logic mode_n, neg_n, err_n, div0;
  logic [TW-1:0] wcnt, wcnt_n;

  function automatic logic [3:0] inc(input logic [3:0] v);
    return v == 4'd9 ? 4'd0 : v + 4'd1;
  endfunction

  // synchronize each button and accept a new level only after it holds for DEBOUNCE_CYCLES samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl <= '0;
      lvl_d <= '0;
      for (int i = 0; i < 9; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      lvl_d <= lvl;
      for (int i = 0; i < 9; i++) begin
        if (sync2[i] == lvl[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          lvl[i] <= sync2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign press = lvl & ~lvl_d;
  assign op_a = 7'(dig[0]) * 7'd10 + 7'(dig[1]);
  assign op_b = 7'(dig[2]) * 7'd10 + 7'(dig[3]);
  assign entry_val = 14'(dig[0]) * 14'd1000 + 14'(dig[1]) * 14'd100 + 14'(dig[2]) * 14'd10 + 14'(dig[3]);
  assign disp_value = disp_mode ? res : entry_val;
  assign busy = state == S_ISSUE || state == S_WAIT;
  assign div0 = op_sel == 3'd4 && op_b == 7'd0;

  // next-state, digit, operation and display decisions; clear overrides everything
  always_comb begin
    state_n = state;
    dig_n = dig;
    op_n = op_sel;
    res_n = res;
    mode_n = disp_mode;
    neg_n = disp_neg;
    err_n = err;
    wcnt_n = wcnt;
    alu_start = 1'b0;
    if (press[8]) begin
      state_n = S_ENTRY;
      for (int i = 0; i < 4; i++) dig_n[i] = 4'd0;
      op_n = 3'd0;
      res_n = '0;
      mode_n = 1'b0;
      neg_n = 1'b0;
      err_n = 1'b0;
    end else begin
      case (state)
        S_ENTRY, S_SHOW: begin
          if (|press[7:4]) begin
            op_n = press[4] ? 3'd1 : press[5] ? 3'd2 : press[6] ? 3'd3 : 3'd4;
            state_n = S_ISSUE;
          end else if (|press[3:0]) begin
            for (int i = 0; i < 4; i++) dig_n[i] = press[i] ? inc(dig[i]) : dig[i];
            state_n = S_ENTRY;
            mode_n = 1'b0;
            neg_n = 1'b0;
            err_n = 1'b0;
          end
        end
        S_ISSUE: begin
          if (div0) begin
            state_n = S_SHOW;
            res_n = '0;
            mode_n = 1'b1;
            neg_n = 1'b0;
            err_n = 1'b1;
          end else begin
            alu_start = 1'b1;
            state_n = S_WAIT;
            wcnt_n = '0;
          end
        end
        S_WAIT: begin
          if (alu_done) begin
            state_n = S_SHOW;
            res_n = alu_result > 14'd9999 ? 14'd9999 : alu_result;
            err_n = alu_result > 14'd9999;
            neg_n = op_sel == 3'd2 && alu_neg;
            mode_n = 1'b1;
          end else if (wcnt == TW'(ALU_TIMEOUT - 1)) begin
            state_n = S_SHOW;
            res_n = '0;
            mode_n = 1'b1;
            neg_n = 1'b0;
            err_n = 1'b1;
          end else wcnt_n = wcnt + 1'b1;
        end
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ENTRY;
      for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
      op_sel <= 3'd0;
      res <= '0;
      disp_mode <= 1'b0;
      disp_neg <= 1'b0;
      err <= 1'b0;
      wcnt <= '0;
    end else begin
      state <= state_n;
      dig <= dig_n;
      op_sel <= op_n;
      res <= res_n;
      disp_mode <= mode_n;
      disp_neg <= neg_n;
      err <= err_n;
      wcnt <= wcnt_n;
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed scoreboard bench with a behavioural arithmetic-unit model
module tb_calc_sequencer;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst;
  logic [8:0] btn;
  logic [6:0] op_a, op_b;
  logic [2:0] op_sel;
  logic alu_start, alu_done, alu_neg, disp_mode, disp_neg, err, busy;
  logic [13:0] alu_result, disp_value;
  typedef struct {logic [13:0] v; logic n, e, m;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, n_start = 0, n_busy = 0, s0, b0;
  int model_lat, model_res;
  logic model_on, model_neg;

  calc_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .btn(btn), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result), .alu_neg(alu_neg),
    .disp_value(disp_value), .disp_mode(disp_mode), .disp_neg(disp_neg), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // count clocks with alu_start and busy high
  always begin
    @(posedge clk);
    #1;
    if (alu_start) n_start++;
    if (busy) n_busy++;
  end

  // arithmetic unit model: answers model_lat clocks after a start when enabled
  always begin
    @(posedge clk);
    #1;
    if (alu_start && model_on) begin
      repeat (model_lat) begin
        @(posedge clk);
        #1;
      end
      alu_done = 1'b1;
      alu_result = 14'(model_res);
      alu_neg = model_neg;
      @(posedge clk);
      #1;
      alu_done = 1'b0;
      alu_result = '0;
      alu_neg = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_mask(input logic [8:0] m);
    btn = m;
    repeat (6) tick();
    btn = '0;
    repeat (8) tick();
  endtask

  task automatic press(input int b);
    press_mask(9'd1 << b);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && busy; k++) tick();
    chk("idle_bound", busy, 0);
  endtask

  task automatic push_exp(input int v, input logic n, input logic e);
    exp_t x;
    x.v = 14'(v);
    x.n = n;
    x.e = e;
    x.m = 1'b1;
    sb.push_back(x);
  endtask

  task automatic check_result(input string tag);
    exp_t x;
    x = sb.pop_front();
    chk({tag, "_value"}, disp_value, x.v);
    chk({tag, "_neg"}, disp_neg, x.n);
    chk({tag, "_err"}, err, x.e);
    chk({tag, "_mode"}, disp_mode, x.m);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_op_a"}, op_a, 0);
    chk({tag, "_op_b"}, op_b, 0);
    chk({tag, "_op_sel"}, op_sel, 0);
    chk({tag, "_start"}, alu_start, 0);
    chk({tag, "_disp"}, disp_value, 0);
    chk({tag, "_mode"}, disp_mode, 0);
    chk({tag, "_neg"}, disp_neg, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    btn = '0;
    rst = 1'b1;
    alu_done = 1'b0;
    alu_result = '0;
    alu_neg = 1'b0;
    model_on = 1'b1;
    model_lat = 5;
    model_res = 0;
    model_neg = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();
    for (int k = 0; k < 12; k++) press(0);
    chk("wrap_a_tens", op_a, 20);
    btn[1] = 1'b1;
    repeat (100) tick();
    btn[1] = 1'b0;
    repeat (8) tick();
    chk("held_once", op_a, 21);
    chk("entry_disp", disp_value, 2100);
    btn[3] = 1'b1;
    repeat (3) tick();
    btn[3] = 1'b0;
    repeat (10) tick();
    chk("glitch", op_b, 0);
    press(8);
    chk("clear_a", op_a, 0);
    for (int k = 0; k < 4; k++) press(0);
    for (int k = 0; k < 7; k++) press(1);
    for (int k = 0; k < 8; k++) press(2);
    for (int k = 0; k < 5; k++) press(3);
    chk("load_a", op_a, 47);
    chk("load_b", op_b, 85);
    chk("load_disp", disp_value, 4785);
    model_lat = 5;
    model_res = 38;
    model_neg = 1'b1;
    s0 = n_start;
    b0 = n_busy;
    push_exp(38, 1'b1, 1'b0);
    press(5);
    wait_idle();
    check_result("sub");
    chk("sub_start_width", n_start - s0, 1);
    chk("sub_busy_clocks", n_busy - b0, 6);
    chk("sub_op_sel", op_sel, 2);
    chk("sub_op_a_stable", op_a, 47);
    press(8);
    press(0);
    press(1);
    press(1);
    chk("div_a", op_a, 12);
    s0 = n_start;
    b0 = n_busy;
    push_exp(0, 1'b0, 1'b1);
    press(7);
    wait_idle();
    check_result("div0");
    chk("div0_no_start", n_start - s0, 0);
    chk("div0_busy_clocks", n_busy - b0, 1);
    chk("div0_op_sel", op_sel, 4);
    model_on = 1'b0;
    s0 = n_start;
    b0 = n_busy;
    push_exp(0, 1'b0, 1'b1);
    press(6);
    wait_idle();
    check_result("timeout");
    chk("timeout_busy_clocks", n_busy - b0, TO + 1);
    chk("timeout_start", n_start - s0, 1);
    press(3);
    chk("digit_err", err, 0);
    chk("digit_mode", disp_mode, 0);
    chk("digit_b", op_b, 1);
    chk("digit_disp", disp_value, 1201);
    model_on = 1'b1;
    model_lat = 3;
    model_res = 12000;
    model_neg = 1'b1;
    push_exp(9999, 1'b0, 1'b1);
    press(6);
    wait_idle();
    check_result("clamp");
    press(8);
    model_lat = 30;
    model_res = 77;
    model_neg = 1'b0;
    press_mask(9'h050);
    chk("prio_op_sel", op_sel, 1);
    chk("prio_busy", busy, 1);
    press(8);
    repeat (30) tick();
    chk("clr_wait_mode", disp_mode, 0);
    chk("clr_wait_disp", disp_value, 0);
    chk("clr_wait_op_sel", op_sel, 0);
    chk("clr_wait_busy", busy, 0);
    chk("clr_wait_err", err, 0);
    press(0);
    model_lat = 40;
    press(4);
    chk("rstw_busy", busy, 1);
    rst = 1'b1;
    tick();
    check_reset("rst_wait");
    rst = 1'b0;
    s0 = n_start;
    repeat (50) tick();
    chk("rstw_no_start", n_start - s0, 0);
    chk("rstw_mode", disp_mode, 0);
    chk("rstw_disp", disp_value, 0);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
